sync_fifo_q: RTL and testbench
==============================

Name: sync_fifo_q

Overview:
Single-clock, first-in-first-out buffer with a parameterised depth and width, built from a register/RAM array plus read and write pointers. It is the generic queue primitive used by the queue manager. One instance is the 8-bit packet data store and another is the 16-bit packet-length (pointer) store. It reports full, empty and an occupancy count so the producer can apply backpressure.

Parameters:
ADDR_WIDTH, 5, log2 of depth; DEPTH = 2**ADDR_WIDTH entries
DATA_WIDTH, 8, width of each stored word

Ports:
clk  in  1  clock, all state updates on rising edge
rstn  in  1  reset, asynchronous, active-low
fifo_wr_data  in  DATA_WIDTH  write data
fifo_wr_en  in  1  write request
fifo_rd_en  in  1  read request
fifo_rd_data  out  DATA_WIDTH  read data, registered
fifo_full  out  1  high when occupancy == DEPTH
fifo_empty  out  1  high when occupancy == 0
data_count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- Reset: asynchronous on rstn low.
  - wr_ptr, rd_ptr and count are cleared to 0.
  - fifo_rd_data is cleared to 0.
  - fifo_empty = 1, fifo_full = 0, data_count = 0.
  - Memory contents are not reset.
  - Asserting reset mid-operation discards all stored entries immediately.
- Pointers are ADDR_WIDTH bits wide and wrap naturally from DEPTH-1 to 0.
- Write: wr_accept = fifo_wr_en & !fifo_full.
  - On an accepted write, mem[wr_ptr] <= fifo_wr_data and wr_ptr increments.
  - A write while full is ignored: no state change, data dropped.
- Read: rd_accept = fifo_rd_en & !fifo_empty.
  - On an accepted read, fifo_rd_data <= mem[rd_ptr] and rd_ptr increments.
  - Latency is one cycle: data is valid on the cycle after the rd_en edge.
  - fifo_rd_data holds its value until the next accepted read.
  - A read while empty is ignored and fifo_rd_data keeps its previous value.
- Count update per edge:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on both or neither.
- Simultaneous read and write:
  - Empty: only the write is accepted; count becomes 1, fifo_rd_data unchanged.
  - Full: only the read is accepted; count becomes DEPTH-1.
  - Otherwise: both are accepted and count is unchanged.
- Flag and count timing: fifo_full, fifo_empty and data_count are derived combinationally from the registered count. They reflect the state after the most recent edge and do not update combinationally from the current request inputs.
- No overflow or underflow of count is possible because of the accept gating.

Decomposition:
- No package is required; DEPTH is a localparam (2**ADDR_WIDTH).
- An optional sub-module, sync_fifo_ram, provides a simple dual-port array: one write port, and one read port with a registered output. Pointer, count and flag logic stay in the top module.

Test Plan:
- Reset, then 3 writes (0xA1, 0xB2, 0xC3) -> data_count = 3, empty = 0. Then 3 reads -> fifo_rd_data = 0xA1, 0xB2, 0xC3, each on the cycle after its rd_en. Afterwards empty = 1, count = 0.
- ADDR_WIDTH = 5: write 32 words -> full = 1, count = 32. A 33rd write is ignored. Reading 32 words returns the original 32 in order.
- Read when empty -> fifo_rd_data holds its last value, count stays 0, empty stays 1.
- Simultaneous wr_en and rd_en at count = 5 -> count stays 5 and data order is preserved. At count = 0 -> count becomes 1. At full -> count becomes 31.
- Wrap-around: push and pop alternately for 100 words through a depth-32 FIFO -> every output equals its input in sequence.
- Assert rstn low asynchronously mid-stream at count = 10 -> count = 0, empty = 1 and fifo_rd_data = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo_q: one write port, one read port with a registered output.
// Read data appears one cycle after rd_en and holds until the next enabled read; no backpressure here.
module sync_fifo_ram #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   // Array is deliberately left unreset so it can map onto RAM macros.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/sync_fifo_q.sv
// Single-clock FIFO of 2**ADDR_WIDTH words; read data registered, valid one cycle after an accepted read.
// Writes while full and reads while empty are dropped; producer throttles on fifo_full / data_count.
module sync_fifo_q #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [DATA_WIDTH-1:0] fifo_wr_data,
   input  logic                  fifo_wr_en,
   input  logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_full,
   output logic                  fifo_empty,
   output logic [ADDR_WIDTH:0]   data_count
);

   localparam int                DEPTH    = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  wr_accept;
   logic                  rd_accept;

   // Flags come from the registered count only, never from the live requests.
   assign fifo_full  = (count == FULL_CNT);
   assign fifo_empty = (count == '0);
   assign data_count = count;

   assign wr_accept = fifo_wr_en & ~fifo_full;
   assign rd_accept = fifo_rd_en & ~fifo_empty;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_accept) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_accept, rd_accept})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   sync_fifo_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (wr_accept),
      .wr_addr (wr_ptr),
      .wr_data (fifo_wr_data),
      .rd_en   (rd_accept),
      .rd_addr (rd_ptr),
      .rd_data (fifo_rd_data)
   );

endmodule

// File: tb/tb_sync_fifo_q.sv
// Directed bench for sync_fifo_q at ADDR_WIDTH=5, DATA_WIDTH=8.
module tb_sync_fifo_q;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] fifo_wr_data = '0;
   logic       fifo_wr_en = 1'b0;
   logic       fifo_rd_en = 1'b0;
   logic [7:0] fifo_rd_data;
   logic       fifo_full;
   logic       fifo_empty;
   logic [5:0] data_count;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   sync_fifo_q #(
      .ADDR_WIDTH (5),
      .DATA_WIDTH (8)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .fifo_wr_data (fifo_wr_data),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .data_count   (data_count)
   );

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      fifo_wr_data = d;
      fifo_wr_en   = 1'b1;
      step();
      fifo_wr_en   = 1'b0;
   endtask

   task automatic pop();
      fifo_rd_en = 1'b1;
      step();
      fifo_rd_en = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      vectors++;
      if (data_count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", data_count); end
      vectors++;
      if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", fifo_empty); end
      vectors++;
      if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", fifo_full); end
      vectors++;
      if (fifo_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", fifo_rd_data); end
      #10;
      rstn = 1'b1;
      step();
   endtask

   task automatic test_basic();
      logic [7:0] exp_d [3];
      exp_d[0] = 8'hA1; exp_d[1] = 8'hB2; exp_d[2] = 8'hC3;
      for (int i = 0; i < 3; i++) push(exp_d[i]);
      vectors++;
      if (data_count !== 6'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", data_count); end
      vectors++;
      if (fifo_empty !== 1'b0) begin errors++; $display("FAIL basic_empty got %b exp 0", fifo_empty); end
      for (int i = 0; i < 3; i++) begin
         pop();
         vectors++;
         if (fifo_rd_data !== exp_d[i]) begin
            errors++; $display("FAIL basic_rd[%0d] got %h exp %h", i, fifo_rd_data, exp_d[i]);
         end
      end
      vectors++;
      if (fifo_empty !== 1'b1) begin errors++; $display("FAIL basic_empty_after got %b exp 1", fifo_empty); end
      vectors++;
      if (data_count !== 6'd0) begin errors++; $display("FAIL basic_count_after got %0d exp 0", data_count); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 32; i++) push(8'(i * 5 + 1));
      vectors++;
      if (fifo_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", fifo_full); end
      vectors++;
      if (data_count !== 6'd32) begin errors++; $display("FAIL fill_count got %0d exp 32", data_count); end
      push(8'hEE);
      vectors++;
      if (data_count !== 6'd32) begin errors++; $display("FAIL overflow_count got %0d exp 32", data_count); end
      vectors++;
      if (fifo_full !== 1'b1) begin errors++; $display("FAIL overflow_full got %b exp 1", fifo_full); end
      for (int i = 0; i < 32; i++) begin
         pop();
         vectors++;
         if (fifo_rd_data !== 8'(i * 5 + 1)) begin
            errors++; $display("FAIL fill_rd[%0d] got %h exp %h", i, fifo_rd_data, 8'(i * 5 + 1));
         end
      end
      vectors++;
      if (fifo_empty !== 1'b1) begin errors++; $display("FAIL fill_empty_after got %b exp 1", fifo_empty); end
   endtask

   task automatic test_read_empty();
      // Last word read by test_fill was 31*5+1 = 0x9C.
      pop();
      pop();
      vectors++;
      if (fifo_rd_data !== 8'h9C) begin errors++; $display("FAIL empty_rd_hold got %h exp 9c", fifo_rd_data); end
      vectors++;
      if (data_count !== 6'd0) begin errors++; $display("FAIL empty_rd_count got %0d exp 0", data_count); end
      vectors++;
      if (fifo_empty !== 1'b1) begin errors++; $display("FAIL empty_rd_empty got %b exp 1", fifo_empty); end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
      fifo_wr_data = 8'h15; fifo_wr_en = 1'b1; fifo_rd_en = 1'b1;
      step();
      fifo_wr_en = 1'b0; fifo_rd_en = 1'b0;
      vectors++;
      if (data_count !== 6'd5) begin errors++; $display("FAIL simul_mid_count got %0d exp 5", data_count); end
      vectors++;
      if (fifo_rd_data !== 8'h10) begin errors++; $display("FAIL simul_mid_rd got %h exp 10", fifo_rd_data); end
      for (int i = 1; i <= 5; i++) begin
         pop();
         vectors++;
         if (fifo_rd_data !== 8'(8'h10 + i)) begin
            errors++; $display("FAIL simul_mid_order[%0d] got %h exp %h", i, fifo_rd_data, 8'(8'h10 + i));
         end
      end
      // Empty: only the write lands.
      fifo_wr_data = 8'h77; fifo_wr_en = 1'b1; fifo_rd_en = 1'b1;
      step();
      fifo_wr_en = 1'b0; fifo_rd_en = 1'b0;
      vectors++;
      if (data_count !== 6'd1) begin errors++; $display("FAIL simul_empty_count got %0d exp 1", data_count); end
      vectors++;
      if (fifo_rd_data !== 8'h15) begin errors++; $display("FAIL simul_empty_rd got %h exp 15", fifo_rd_data); end
      pop();
      vectors++;
      if (fifo_rd_data !== 8'h77) begin errors++; $display("FAIL simul_empty_data got %h exp 77", fifo_rd_data); end
      // Full: only the read lands, 0x99 is dropped.
      for (int i = 0; i < 32; i++) push(8'(8'h40 + i));
      fifo_wr_data = 8'h99; fifo_wr_en = 1'b1; fifo_rd_en = 1'b1;
      step();
      fifo_wr_en = 1'b0; fifo_rd_en = 1'b0;
      vectors++;
      if (data_count !== 6'd31) begin errors++; $display("FAIL simul_full_count got %0d exp 31", data_count); end
      vectors++;
      if (fifo_rd_data !== 8'h40) begin errors++; $display("FAIL simul_full_rd got %h exp 40", fifo_rd_data); end
      for (int i = 1; i < 32; i++) begin
         pop();
         vectors++;
         if (fifo_rd_data !== 8'(8'h40 + i)) begin
            errors++; $display("FAIL simul_full_drain[%0d] got %h exp %h", i, fifo_rd_data, 8'(8'h40 + i));
         end
      end
      vectors++;
      if (fifo_empty !== 1'b1) begin errors++; $display("FAIL simul_full_empty got %b exp 1", fifo_empty); end
   endtask

   task automatic test_wrap();
      logic [7:0] d;
      for (int i = 0; i < 100; i++) begin
         d = 8'(i * 3) ^ 8'h5A;
         push(d);
         pop();
         vectors++;
         if (fifo_rd_data !== d) begin
            errors++; $display("FAIL wrap[%0d] got %h exp %h", i, fifo_rd_data, d);
         end
      end
      vectors++;
      if (data_count !== 6'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", data_count); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 11; i++) push(8'(8'hC0 + i));
      pop();
      vectors++;
      if (data_count !== 6'd10) begin errors++; $display("FAIL arst_pre_count got %0d exp 10", data_count); end
      vectors++;
      if (fifo_rd_data !== 8'hC0) begin errors++; $display("FAIL arst_pre_rd got %h exp c0", fifo_rd_data); end
      // Mid-cycle, well clear of any rising edge.
      #2;
      rstn = 1'b0;
      #1;
      vectors++;
      if (data_count !== 6'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", data_count); end
      vectors++;
      if (fifo_empty !== 1'b1) begin errors++; $display("FAIL arst_empty got %b exp 1", fifo_empty); end
      vectors++;
      if (fifo_rd_data !== 8'h00) begin errors++; $display("FAIL arst_rd got %h exp 00", fifo_rd_data); end
      step();
      rstn = 1'b1;
      push(8'h3C);
      pop();
      vectors++;
      if (fifo_rd_data !== 8'h3C) begin errors++; $display("FAIL arst_resume got %h exp 3c", fifo_rd_data); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_read_empty();
      test_simultaneous();
      test_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
